// File: rtl/elevator_passenger_agent.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_passenger_agent
//  Description : Synthesizable passenger emulator for the button/indicator
//                side of an elevator controller. A trip (src, dst) is taken
//                on a valid/ready handshake. The agent presses the hall button
//                and waits for the door to open at src. After a boarding delay
//                it presses the car button for dst and waits for the door to
//                open there. It then reports completion with the elapsed cycle
//                count and an error flag.
//  Ports       : clk, rstn (sync, active-low)
//                trip_valid/trip_ready/trip_src/trip_dst  request handshake
//                floor_[1..3]_out, elevator_door_open_out controller status
//                floor_*_button_pressed, elevator_floor_*   button pulses
//                trip_done/trip_error/trip_cycles         completion report
//  Option      : AGENT_RETRY_EN - one hall-button retry on pickup timeout
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_passenger_agent #(
    parameter int PRESS_CYCLES = 1,
    parameter int BOARD_DELAY  = 5,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             trip_valid,
    output logic             trip_ready,
    input  logic [1:0]       trip_src,
    input  logic [1:0]       trip_dst,
    input  logic             floor_1_out,
    input  logic             floor_2_out,
    input  logic             floor_3_out,
    input  logic             elevator_door_open_out,
    output logic             floor_1_up_button_pressed,
    output logic             floor_2_up_button_pressed,
    output logic             floor_2_down_button_pressed,
    output logic             floor_3_down_button_pressed,
    output logic             elevator_floor_1_button_pressed,
    output logic             elevator_floor_2_button_pressed,
    output logic             elevator_floor_3_button_pressed,
    output logic             trip_done,
    output logic             trip_error,
    output logic [CNT_W-1:0] trip_cycles
);

    // The wait counter must hold the largest of the three timed durations.
    localparam int c_wait_max_a = (TIMEOUT > BOARD_DELAY) ? TIMEOUT : BOARD_DELAY;
    localparam int c_wait_max   = (c_wait_max_a > PRESS_CYCLES) ? c_wait_max_a : PRESS_CYCLES;
    localparam int c_wait_w     = $clog2(c_wait_max + 2);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_HALL_PRESS  = 3'd1,
        S_WAIT_PICKUP = 3'd2,
        S_BOARD       = 3'd3,
        S_CAR_PRESS   = 3'd4,
        S_WAIT_ARRIVE = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            src_q, src_d;
    logic [1:0]            dst_q, dst_d;
    logic [c_wait_w-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]      cycles_q, cycles_d;
    logic                  door_q, door_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    // Button vector: [6] f1 up, [5] f2 up, [4] f2 down, [3] f3 down,
    //                [2] car 1, [1] car 2, [0] car 3
    logic [6:0]            btn_q, btn_d;
`ifdef AGENT_RETRY_EN
    logic                  retry_q, retry_d;
`endif

    logic [2:0]            w_floor;
    logic                  w_door_rise;
    logic                  w_at_src;
    logic                  w_at_dst;
    int                    w_wait_cnt;

    function automatic logic [2:0] floor_code(input logic [1:0] n);
        case (n)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign w_floor     = {floor_3_out, floor_2_out, floor_1_out};
    assign w_door_rise = elevator_door_open_out & ~door_q;
    assign w_at_src    = (w_floor == floor_code(src_q));
    assign w_at_dst    = (w_floor == floor_code(dst_q));
    assign w_wait_cnt  = int'(wait_q);
    assign door_d      = elevator_door_open_out;

    // Next-state and trip bookkeeping
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        error_d  = 1'b0;
        cycles_d = cycles_q;
`ifdef AGENT_RETRY_EN
        retry_d  = retry_q;
`endif
        // Elapsed count runs through every active state and saturates.
        if (state_q != S_IDLE && state_q != S_DONE && cycles_q != '1) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trip_valid) begin
                    src_d    = trip_src;
                    dst_d    = trip_dst;
                    cycles_d = '0;
`ifdef AGENT_RETRY_EN
                    retry_d  = 1'b0;
`endif
                    if (trip_src == 2'd0 || trip_dst == 2'd0 || trip_src == trip_dst) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_HALL_PRESS;
                    end
                end
            end
            S_HALL_PRESS: begin
                if (w_wait_cnt + 1 >= PRESS_CYCLES) state_d = S_WAIT_PICKUP;
            end
            S_WAIT_PICKUP: begin
                // A door edge on the timeout cycle still counts as a pickup.
                if (w_door_rise && w_at_src) begin
                    state_d = S_BOARD;
                end else if (w_wait_cnt >= TIMEOUT) begin
`ifdef AGENT_RETRY_EN
                    if (!retry_q) begin
                        state_d = S_HALL_PRESS;
                        retry_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    error_d = 1'b1;
`endif
                end
            end
            S_BOARD: begin
                if (w_wait_cnt + 1 >= BOARD_DELAY) state_d = S_CAR_PRESS;
            end
            S_CAR_PRESS: begin
                if (w_wait_cnt + 1 >= PRESS_CYCLES) state_d = S_WAIT_ARRIVE;
            end
            S_WAIT_ARRIVE: begin
                if (w_door_rise && w_at_dst) begin
                    state_d = S_DONE;
                end else if (w_wait_cnt >= TIMEOUT) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Every timed state starts counting from zero on entry.
        if (state_d != state_q || state_q == S_IDLE) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state register cycle-for-cycle.
    always_comb begin
        btn_d   = '0;
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_HALL_PRESS) begin
            if (dst_d > src_d) begin
                if (src_d == 2'd1) btn_d[6] = 1'b1;
                else               btn_d[5] = 1'b1;
            end else begin
                if (src_d == 2'd2) btn_d[4] = 1'b1;
                else               btn_d[3] = 1'b1;
            end
        end else if (state_d == S_CAR_PRESS) begin
            case (dst_d)
                2'd1:    btn_d[2] = 1'b1;
                2'd2:    btn_d[1] = 1'b1;
                2'd3:    btn_d[0] = 1'b1;
                default: btn_d    = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            wait_q   <= '0;
            cycles_q <= '0;
            door_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            btn_q    <= '0;
`ifdef AGENT_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            wait_q   <= wait_d;
            cycles_q <= cycles_d;
            door_q   <= door_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            error_q  <= error_d;
            btn_q    <= btn_d;
`ifdef AGENT_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign trip_ready                      = ready_q;
    assign trip_done                       = done_q;
    assign trip_error                      = error_q;
    assign trip_cycles                     = cycles_q;
    assign floor_1_up_button_pressed       = btn_q[6];
    assign floor_2_up_button_pressed       = btn_q[5];
    assign floor_2_down_button_pressed     = btn_q[4];
    assign floor_3_down_button_pressed     = btn_q[3];
    assign elevator_floor_1_button_pressed = btn_q[2];
    assign elevator_floor_2_button_pressed = btn_q[1];
    assign elevator_floor_3_button_pressed = btn_q[0];

endmodule
`default_nettype wire

// File: tb/tb_elevator_passenger_agent.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_passenger_agent
//  Description : Randomized self-checking bench. Each trip is run against a
//                scripted floor/door waveform; a trip-level model derives the
//                expected button pulses, completion cycle, error flag and
//                cycle count from the waveform.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elevator_passenger_agent;

    localparam int P    = 1;
    localparam int B    = 5;
    localparam int T    = 20;
    localparam int CW   = 16;
    localparam int MAXL = 100;
`ifdef AGENT_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          trip_valid;
    logic          trip_ready;
    logic [1:0]    trip_src;
    logic [1:0]    trip_dst;
    logic          floor_1_out, floor_2_out, floor_3_out;
    logic          door;
    logic          f1_up, f2_up, f2_dn, f3_dn, c1, c2, c3;
    logic          trip_done;
    logic          trip_error;
    logic [CW-1:0] trip_cycles;

    always #5 clk = ~clk;

    elevator_passenger_agent #(
        .PRESS_CYCLES (P),
        .BOARD_DELAY  (B),
        .TIMEOUT      (T),
        .CNT_W        (CW)
    ) u_dut (
        .clk                             (clk),
        .rstn                            (rstn),
        .trip_valid                      (trip_valid),
        .trip_ready                      (trip_ready),
        .trip_src                        (trip_src),
        .trip_dst                        (trip_dst),
        .floor_1_out                     (floor_1_out),
        .floor_2_out                     (floor_2_out),
        .floor_3_out                     (floor_3_out),
        .elevator_door_open_out          (door),
        .floor_1_up_button_pressed       (f1_up),
        .floor_2_up_button_pressed       (f2_up),
        .floor_2_down_button_pressed     (f2_dn),
        .floor_3_down_button_pressed     (f3_dn),
        .elevator_floor_1_button_pressed (c1),
        .elevator_floor_2_button_pressed (c2),
        .elevator_floor_3_button_pressed (c3),
        .trip_done                       (trip_done),
        .trip_error                      (trip_error),
        .trip_cycles                     (trip_cycles)
    );

    wire [6:0] btn = {f1_up, f2_up, f2_dn, f3_dn, c1, c2, c3};

    int         n_vectors     = 0;
    int         n_miscompares = 0;
    logic       door_arr [MAXL];
    logic [2:0] flr_arr  [MAXL];
    logic [6:0] exp_btn  [MAXL];
    int         exp_done;
    logic       exp_err;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int n);
        logic [2:0] v;
        v = 3'b001;
        v = v << (n - 1);
        return v;
    endfunction

    function automatic logic rise(input int r);
        if (r == 0) return door_arr[0];
        return door_arr[r] && !door_arr[r-1];
    endfunction

    task automatic clear_env(input int idle_floor, input bit noisy);
        logic [2:0] junk [6];
        junk = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110};
        for (int k = 0; k < MAXL; k++) begin
            door_arr[k] = 1'b0;
            flr_arr[k]  = noisy ? junk[$urandom_range(0, 5)] : oh(idle_floor);
        end
    endtask

    task automatic add_open(input int f, input int start, input int len);
        for (int k = start; k < start + len; k++) begin
            if (k < MAXL) begin
                door_arr[k] = 1'b1;
                flr_arr[k]  = oh(f);
            end
        end
    endtask

    // Trip-level expectation: offset k is the k-th cycle after the accept edge.
    task automatic model(input int s, input int d);
        int h, ws, pick, w;
        bit found;
        for (int k = 0; k < MAXL; k++) exp_btn[k] = '0;
        exp_err = 1'b0;
        if (s == 0 || d == 0 || s == d) begin
            exp_done = 0;
            exp_err  = 1'b1;
            return;
        end
        h = 0; found = 0; pick = 0;
        for (int a = 0; a < ATTEMPTS && !found; a++) begin
            for (int k = h; k < h + P; k++)
                exp_btn[k][(d > s) ? ((s == 1) ? 6 : 5) : ((s == 2) ? 4 : 3)] = 1'b1;
            ws = h + P;
            for (int r = ws; r <= ws + T && !found; r++) begin
                if (rise(r) && flr_arr[r] == oh(s)) begin
                    found = 1;
                    pick  = r;
                end
            end
            if (!found) h = ws + T + 1;
        end
        if (!found) begin
            exp_done = h;
            exp_err  = 1'b1;
            return;
        end
        for (int k = pick + B + 1; k <= pick + B + P; k++) exp_btn[k][3 - d] = 1'b1;
        w = pick + B + P + 1;
        exp_done = w + T + 1;
        exp_err  = 1'b1;
        for (int r = w; r <= w + T; r++) begin
            if (rise(r) && flr_arr[r] == oh(d)) begin
                exp_done = r + 1;
                exp_err  = 1'b0;
                break;
            end
        end
    endtask

    task automatic drive(input int k);
        {floor_3_out, floor_2_out, floor_1_out} = flr_arr[k];
        door = door_arr[k];
    endtask

    // Called at a negedge with the door closed. abort_at >= 0 pulls reset low
    // in that cycle of the trip.
    task automatic exec_trip(input int s, input int d, input int abort_at);
        model(s, d);
        check_value("ready_before_request", 32'(trip_ready), 32'd1);
        trip_valid = 1'b1;
        trip_src   = 2'(s);
        trip_dst   = 2'(d);
        @(posedge clk);
        @(negedge clk);
        trip_valid = 1'b0;
        trip_src   = 2'($urandom);
        trip_dst   = 2'($urandom);
        for (int k = 0; k <= exp_done + 1; k++) begin
            drive(k);
            check_value($sformatf("buttons s%0d d%0d cyc%0d", s, d, k), 32'(btn), 32'(exp_btn[k]));
            check_value($sformatf("done s%0d d%0d cyc%0d", s, d, k), 32'(trip_done), 32'(k == exp_done));
            check_value($sformatf("ready s%0d d%0d cyc%0d", s, d, k), 32'(trip_ready), 32'(k > exp_done));
            if (k == exp_done)
                check_value($sformatf("error s%0d d%0d", s, d), 32'(trip_error), 32'(exp_err));
            if (k >= exp_done)
                check_value($sformatf("cycles s%0d d%0d cyc%0d", s, d, k), 32'(trip_cycles), 32'(exp_done));
            if (k == abort_at) begin
                rstn = 1'b0;
                @(negedge clk);
                check_value("reset_buttons", 32'(btn), 32'd0);
                check_value("reset_done", 32'(trip_done), 32'd0);
                check_value("reset_error", 32'(trip_error), 32'd0);
                check_value("reset_cycles", 32'(trip_cycles), 32'd0);
                check_value("reset_ready", 32'(trip_ready), 32'd1);
                rstn = 1'b1;
                break;
            end
            @(negedge clk);
        end
        door = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic random_trip();
        int s, d, p;
        s = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        if ($urandom_range(0, 7) != 0) begin
            s = $urandom_range(1, 3);
            d = (s + $urandom_range(0, 1)) % 3 + 1;
        end
        clear_env($urandom_range(1, 3), 1'b1);
        repeat ($urandom_range(0, 3))
            add_open($urandom_range(1, 3), $urandom_range(0, 70), $urandom_range(1, 4));
        if (s != 0 && d != 0 && $urandom_range(0, 3) != 0) begin
            p = P + $urandom_range(0, T + 2);
            add_open(s, p, $urandom_range(1, 4));
            if ($urandom_range(0, 3) != 0)
                add_open(d, p + 5 + B + P + $urandom_range(0, T + 2), $urandom_range(1, 4));
        end
        exec_trip(s, d, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn       = 1'b0;
        trip_valid = 1'b0;
        trip_src   = 2'd0;
        trip_dst   = 2'd0;
        {floor_3_out, floor_2_out, floor_1_out} = 3'b001;
        door       = 1'b0;
        repeat (3) @(negedge clk);
        check_value("init_buttons", 32'(btn), 32'd0);
        check_value("init_done", 32'(trip_done), 32'd0);
        check_value("init_error", 32'(trip_error), 32'd0);
        check_value("init_cycles", 32'(trip_cycles), 32'd0);
        check_value("init_ready", 32'(trip_ready), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Car at floor 1, trip 1 -> 2.
        clear_env(1, 1'b0);
        add_open(1, 4, 3);
        add_open(2, 18, 3);
        exec_trip(1, 2, -1);

        // Car at floor 3, trip 2 -> 1; floor-3 opening and a floor-2 reopen ignored.
        clear_env(3, 1'b0);
        add_open(3, 2, 2);
        add_open(2, 8, 3);
        add_open(2, 20, 2);
        add_open(1, 28, 3);
        exec_trip(2, 1, -1);

        // Trip 1 -> 3 with an intermediate stop at floor 2.
        clear_env(1, 1'b0);
        add_open(1, 3, 2);
        add_open(2, 14, 3);
        add_open(3, 22, 3);
        exec_trip(1, 3, -1);

        // Invalid requests.
        exec_trip(2, 2, -1);
        exec_trip(0, 3, -1);
        exec_trip(3, 0, -1);

        // Controller never responds: pickup timeout.
        clear_env(1, 1'b0);
        exec_trip(1, 3, -1);

        // Door edges landing on the last cycle of each wait window.
        clear_env(2, 1'b0);
        add_open(2, P + T, 2);
        add_open(3, P + T + B + P + 1 + T, 2);
        exec_trip(2, 3, -1);

        // Reset in the middle of the arrival wait, then a normal trip.
        clear_env(1, 1'b0);
        add_open(1, 2, 3);
        exec_trip(1, 2, 12);
        clear_env(1, 1'b0);
        add_open(1, 4, 3);
        add_open(2, 18, 3);
        exec_trip(1, 2, -1);

        for (int i = 0; i < 60; i++) random_trip();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_passenger_agent.md
Name: elevator_passenger_agent

Overview:
- Synthesizable passenger emulator that sits on the button/indicator side of elevator_top.
- Accepts a trip request (source floor, destination floor) on a valid/ready handshake, then pulses the matching hall button and waits for the door to open at the source floor.
- After a boarding delay, pulses the car button for the destination and waits for the door to open there.
- Reports completion with the elapsed cycle count and an error flag. Used for hardware self-test and soak runs.

Parameters:
- PRESS_CYCLES, 1, width of every button pulse in clk cycles (>=1).
- BOARD_DELAY, 5, cycles between pickup door-open edge and car-button press.
- TIMEOUT, 255, maximum cycles allowed in each wait state before error.
- CNT_W, 16, width of the trip cycle counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- trip_valid  in  1  trip request valid
- trip_ready  out  1  agent can accept a request
- trip_src  in  2  source floor, 1..3
- trip_dst  in  2  destination floor, 1..3
- floor_1_out  in  1  controller floor-1 indicator
- floor_2_out  in  1  controller floor-2 indicator
- floor_3_out  in  1  controller floor-3 indicator
- elevator_door_open_out  in  1  controller door-open indicator
- floor_1_up_button_pressed  out  1  hall button pulse
- floor_2_up_button_pressed  out  1  hall button pulse
- floor_2_down_button_pressed  out  1  hall button pulse
- floor_3_down_button_pressed  out  1  hall button pulse
- elevator_floor_1_button_pressed  out  1  car button pulse
- elevator_floor_2_button_pressed  out  1  car button pulse
- elevator_floor_3_button_pressed  out  1  car button pulse
- trip_done  out  1  one-cycle completion pulse
- trip_error  out  1  qualifies trip_done; 1 = invalid request or timeout
- trip_cycles  out  CNT_W  cycles from accept to done; held until next accept

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state = IDLE.
  - All button outputs 0; trip_done 0; trip_error 0; trip_cycles 0.
  - trip_ready 1 once rstn is high.
  - Reset mid-trip aborts the trip with no done pulse.
- All outputs are registered.
- Door edge: door_q is a registered copy of elevator_door_open_out; door_rise = door & ~door_q. door_q resets to 0.
- Floor vector: F = {floor_3_out, floor_2_out, floor_1_out}. "At floor n" means F equals the one-hot code for n exactly.
- Handshake:
  - Accept when trip_valid & trip_ready at a posedge. src and dst are latched on accept.
  - trip_ready = (state == IDLE).
  - On accept, trip_cycles clears to 0. It then increments every cycle until DONE and saturates at all-ones.
- States:
  - IDLE:
    - On accept with src in 1..3, dst in 1..3 and src != dst, go to HALL_PRESS.
    - Otherwise (src = 0, dst = 0 or src == dst), go to DONE with error = 1.
  - HALL_PRESS:
    - Assert the hall button for PRESS_CYCLES cycles, then go to WAIT_PICKUP.
    - Button choice: up if dst > src, down if dst < src (src = 1 is always up, src = 3 is always down).
  - WAIT_PICKUP:
    - On door_rise while at src, go to BOARD.
    - Door openings at other floors are ignored.
    - After TIMEOUT cycles, go to DONE with error = 1.
  - BOARD: wait BOARD_DELAY cycles, then go to CAR_PRESS.
  - CAR_PRESS: assert elevator_floor_<dst>_button_pressed for PRESS_CYCLES cycles, then go to WAIT_ARRIVE.
  - WAIT_ARRIVE:
    - On door_rise while at dst, go to DONE with error = 0.
    - Intermediate-floor stops are ignored.
    - After TIMEOUT cycles, go to DONE with error = 1.
  - DONE: trip_done = 1 for exactly one cycle with trip_error valid, then go to IDLE.
- Wait counter: clears on entry to each timed state. The timeout fires when the count reaches TIMEOUT.
- Simultaneous door_rise and timeout in the same cycle: door_rise wins (success path).
- At most one button output is high in any cycle.

Optional Feature:
- Macro: AGENT_RETRY_EN.
- Defined: the first timeout in WAIT_PICKUP re-enters HALL_PRESS once (wait counter cleared, button re-pulsed). A second timeout goes to DONE with error = 1. trip_cycles keeps counting across the retry.
- Undefined: the first timeout in WAIT_PICKUP goes directly to DONE with error = 1.

Test Plan:
- Car idle at floor 1, trip src=1 dst=2 -> floor_1_up pulse of 1 cycle; after the floor-1 door_rise plus 5 cycles, elevator_floor_2 pulse; trip_done with error=0 after the door opens at floor 2; trip_cycles equals the measured accept-to-done count.
- Car at floor 3, trip src=2 dst=1 -> floor_2_down pulse; door opening at floor 2 accepted; done with error=0 only on the floor-1 door_rise.
- Trip src=1 dst=3 while a second stimulus pulses floor_2_up so the car stops at floor 2 -> the floor-2 door_rise is ignored; done fires on the floor-3 door_rise.
- Trip src=2 dst=2, then a separate trip src=0 dst=3 -> each yields trip_done=1 and trip_error=1 in the cycle after accept, with no button pulse.
- Controller held in reset, trip src=1 dst=3, TIMEOUT=20 -> error done after the wait expires. trip_cycles = 1 + 1 + 20 + 1 (±1 per implementation, checked exactly against the RTL state diagram). With AGENT_RETRY_EN defined: two floor_1_up pulses, then error.
- rstn driven low during WAIT_ARRIVE -> the next posedge shows all outputs 0, trip_ready=1 and no trip_done. A new trip then completes normally.
